// File: rtl/screen_select_ctl.sv
// rtl/screen_select_ctl.sv - frame-synchronous screen/mode selector with menu hit-testing
//
// Picks one of N_SCREENS pre-timed video sources (source 0 is the menu) and
// drives registered VGA outputs from it. Clicking a menu button arms a screen
// change that commits only on the next vsync rising edge. The last button
// cycles the difficulty level. The return button goes back to the menu.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-low reset
//   vsync_in            raw frame vsync, used only for frame-boundary detect
//   xpos, ypos          mouse position
//   mouse_left, button  level inputs; rising edges are used
//   src_vsync/hsync/rgb per-source video; source k occupies bit k / rgb[12k+11:12k]
//   screen, difficulty  committed screen index and current difficulty level
//   vsync_out, hsync_out, rgb_out  registered video from the selected source
//
// Build option: SCREEN_SWITCH_BLANK_EN forces rgb_out to 0 for one full frame
// after any commit that changes the screen.

module screen_select_ctl #(
  parameter int N_SCREENS   = 3,
  parameter int DIFF_LEVELS = 2,
  parameter int BTN_X0      = 362,
  parameter int BTN_W       = 313,
  parameter int BTN_Y0      = 46,
  parameter int BTN_H       = 101,
  parameter int BTN_PITCH   = 288
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vsync_in,
  input  logic [11:0]             xpos,
  input  logic [11:0]             ypos,
  input  logic                    mouse_left,
  input  logic                    button,
  input  logic [N_SCREENS-1:0]    src_vsync,
  input  logic [N_SCREENS-1:0]    src_hsync,
  input  logic [12*N_SCREENS-1:0] src_rgb,
  output logic [2:0]              screen,
  output logic [2:0]              difficulty,
  output logic                    vsync_out,
  output logic                    hsync_out,
  output logic [11:0]             rgb_out
);

  localparam logic [1:0] S_MENU   = 2'd0;
  localparam logic [1:0] S_PEND   = 2'd1;
  localparam logic [1:0] S_SCREEN = 2'd2;

  logic [1:0]  state, state_n;
  logic [2:0]  target, target_n;
  logic [2:0]  screen_n;
  logic [2:0]  diff_n;
  logic [2:0]  commit_tgt;
  logic        mouse_left_q, button_q, vsync_q;
  logic        click, ret, frame;
  logic        x_hit, hit;
  logic [2:0]  hit_idx;
  logic [15:0] x_ext, y_ext;
  logic        sel_vsync, sel_hsync;
  logic [11:0] sel_rgb;
`ifdef SCREEN_SWITCH_BLANK_EN
  logic        blank_q, blank_n;
`endif

  // Single-cycle pulses from the current sample against last cycle's sample.
  assign click = mouse_left & ~mouse_left_q;
  assign ret   = button & ~button_q;
  assign frame = vsync_in & ~vsync_q;

  // Widened so that button edge arithmetic cannot wrap.
  assign x_ext = {4'b0, xpos};
  assign y_ext = {4'b0, ypos};
  assign x_hit = (x_ext >= 16'(BTN_X0)) && (x_ext <= 16'(BTN_X0 + BTN_W - 1));

  // Buttons never overlap, so at most one index matches.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int k = 0; k < N_SCREENS; k++) begin
      if (x_hit &&
          (y_ext >= 16'(BTN_Y0 + k * BTN_PITCH)) &&
          (y_ext <= 16'(BTN_Y0 + k * BTN_PITCH + BTN_H - 1))) begin
        hit     = 1'b1;
        hit_idx = 3'(k);
      end
    end
  end

  // State register, edge-detect history and registered video outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_MENU;
      target       <= 3'd0;
      screen       <= 3'd0;
      difficulty   <= 3'd0;
      mouse_left_q <= 1'b0;
      button_q     <= 1'b0;
      vsync_q      <= 1'b0;
      vsync_out    <= 1'b0;
      hsync_out    <= 1'b0;
      rgb_out      <= 12'd0;
`ifdef SCREEN_SWITCH_BLANK_EN
      blank_q      <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      target       <= target_n;
      screen       <= screen_n;
      difficulty   <= diff_n;
      mouse_left_q <= mouse_left;
      button_q     <= button;
      vsync_q      <= vsync_in;
      vsync_out    <= sel_vsync;
      hsync_out    <= sel_hsync;
      rgb_out      <= sel_rgb;
`ifdef SCREEN_SWITCH_BLANK_EN
      blank_q      <= blank_n;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_n    = state;
    target_n   = target;
    screen_n   = screen;
    diff_n     = difficulty;
    // A return in the commit cycle wins: the cancelled target is never shown.
    commit_tgt = ret ? 3'd0 : target;
    case (state)
      S_MENU: begin
        if (click && hit) begin
          if (hit_idx == 3'(N_SCREENS - 1)) begin
            diff_n = (difficulty == 3'(DIFF_LEVELS - 1)) ? 3'd0 : difficulty + 3'd1;
          end else begin
            target_n = hit_idx + 3'd1;
            state_n  = S_PEND;
          end
        end
      end
      S_PEND: begin
        if (ret) target_n = 3'd0;
        if (frame) begin
          screen_n = commit_tgt;
          state_n  = (commit_tgt != 3'd0) ? S_SCREEN : S_MENU;
        end
      end
      S_SCREEN: begin
        if (ret) begin
          target_n = 3'd0;
          state_n  = S_PEND;
        end
      end
      default: state_n = S_MENU;
    endcase
  end

`ifdef SCREEN_SWITCH_BLANK_EN
  // Blank from a screen-changing commit until the following frame pulse.
  always_comb begin
    blank_n = blank_q;
    if (frame) blank_n = 1'b0;
    if (state == S_PEND && frame && commit_tgt != screen) blank_n = 1'b1;
  end
`endif

  // Output selection; an out-of-range screen index falls back to source 0.
  always_comb begin
    sel_vsync = src_vsync[0];
    sel_hsync = src_hsync[0];
    sel_rgb   = src_rgb[11:0];
    for (int k = 1; k < N_SCREENS; k++) begin
      if (screen == 3'(k)) begin
        sel_vsync = src_vsync[k];
        sel_hsync = src_hsync[k];
        sel_rgb   = src_rgb[12*k +: 12];
      end
    end
`ifdef SCREEN_SWITCH_BLANK_EN
    if (blank_q) sel_rgb = 12'd0;
`endif
  end

endmodule

// File: doc/screen_select_ctl.md
Name: screen_select_ctl

Overview:
- Parametrised successor to the top-level screen/mode controller.
- Selects one of N_SCREENS pre-timed video sources (index 0 = menu) and drives the registered VGA outputs.
- Menu hit-testing uses N_SCREENS stacked buttons. Buttons 0..N_SCREENS-2 enter screens 1..N_SCREENS-1; the last button cycles a multi-level difficulty.
- Screen changes commit only on a frame boundary, so there is no tearing. Mouse click and return button are edge-detected.

Parameters:
- N_SCREENS, 3, number of sources/screens incl. menu (2..8).
- DIFF_LEVELS, 2, number of difficulty levels (2..8).
- BTN_X0, 362, button left edge (inclusive).
- BTN_W, 313, button width; right edge = BTN_X0+BTN_W-1.
- BTN_Y0, 46, top edge of button 0.
- BTN_H, 101, button height; bottom edge = top+BTN_H-1.
- BTN_PITCH, 288, vertical distance between button tops.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- vsync_in  in  1  raw frame vsync, used only for frame-boundary detect.
- xpos  in  12  mouse x.
- ypos  in  12  mouse y.
- mouse_left  in  1  mouse left button, level.
- button  in  1  board return button, level, pre-debounced.
- src_vsync  in  N_SCREENS  per-source vsync; bit k = source k.
- src_hsync  in  N_SCREENS  per-source hsync.
- src_rgb  in  12*N_SCREENS  per-source rgb; bits [12k+11:12k] = source k.
- screen  out  3  committed screen index.
- difficulty  out  3  current difficulty level.
- vsync_out  out  1  registered selected vsync.
- hsync_out  out  1  registered selected hsync.
- rgb_out  out  12  registered selected rgb.

Behaviour:
- Reset (rst=0): all outputs 0. State MENU. Target 0. Edge-detect history registers 0.
- Edge detect:
  - click = mouse_left & ~mouse_left_q.
  - ret = button & ~button_q.
  - frame = vsync_in & ~vsync_q (rising edge).
  - All three are single-cycle pulses, registered from the previous cycle's samples.
- Hit test for button k: BTN_X0 <= xpos <= BTN_X0+BTN_W-1 and Yk <= ypos <= Yk+BTN_H-1, with Yk = BTN_Y0+k*BTN_PITCH. Compute Yk in ≥14-bit width, no overflow. Buttons do not overlap; at most one hit.
- FSM states: MENU, PEND, SCREEN.
  - MENU:
    - click on button k < N_SCREENS-1 → target=k+1, go to PEND.
    - click on last button → difficulty = (difficulty+1) mod DIFF_LEVELS; stay in MENU.
    - click elsewhere, or ret → no change.
  - PEND:
    - click ignored.
    - ret → target=0 (cancel); stay in PEND.
    - frame → screen<=target; go to SCREEN if target≠0, else MENU.
    - frame and ret in same cycle → ret applies first, so screen<=0 and go to MENU.
  - SCREEN:
    - click ignored; difficulty frozen.
    - ret → target=0, go to PEND.
- Output path: {vsync_out, hsync_out, rgb_out} <= source[screen] on every cycle. Latency is 1 clk from src_* to outputs. The source change takes effect the cycle after screen updates.
- difficulty: held during PEND and SCREEN. Never reaches DIFF_LEVELS.
- Held mouse_left generates exactly one click, so no auto-repeat difficulty toggling.
- Index guard: if screen ≥ N_SCREENS (unreachable), select source 0.
- Reset mid-PEND: pending target discarded; back to MENU, screen=0.

Optional Feature:
- Macro: SCREEN_SWITCH_BLANK_EN.
- Defined:
  - After every commit that changes screen, rgb_out is forced to 0 until the next frame pulse. That is one full blank frame.
  - Sync outputs still follow the new source.
  - A ret during the blank frame is handled normally.
- Undefined: no blanking; rgb_out follows the selected source immediately.

Test Plan:
- Reset then release, defaults → all outputs 0 and screen=0. rgb_out equals src_rgb[11:0] one clk after a change.
- Click at (400,100), then vsync rising edge 500 clk later → screen stays 0 until that edge, then becomes 1. rgb_out shows src_rgb[23:12] starting 2 clk after the edge.
- Click at (400,650) four times, DIFF_LEVELS=3 → difficulty 1,2,0,1. mouse_left held 1000 clk counts as one click.
- In screen 2: ret and click at (400,100) in the same cycle → go to PEND with target 0; next frame gives screen=0, not 1.
- Click at (400,380) entering PEND, then ret before the frame edge → screen never leaves 0.
- Boundary hits: (361,46) and (675,146) miss; (362,46) and (674,146) hit button 0. With SCREEN_SWITCH_BLANK_EN defined, rgb_out=0 for a full frame after the commit.
